// File: rtl/tensor_unit_pipe.sv
// tensor_unit_pipe: two-stage valid/ready BF16 tensor unit with a per-lane
// multiply-accumulate register. S1 holds the accepted operands, lane
// arithmetic is combinational from S1, and S2 holds the result presented
// downstream.
module tensor_unit_pipe #(
    parameter int LANES  = 4,
    parameter bit ACC_EN = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [5:0]          tu_op,
    input  logic [16*LANES-1:0] rs1_data,
    input  logic [16*LANES-1:0] rs2_data,
    input  logic [16*LANES-1:0] rs3_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16*LANES-1:0] tu_result,
    output logic [16*LANES-1:0] acc_data
);

    localparam int W = 16 * LANES;

    localparam logic [5:0] OP_MUL  = 6'b010000;
    localparam logic [5:0] OP_FMA  = 6'b010001;
    localparam logic [5:0] OP_MAC  = 6'b010010;
    localparam logic [5:0] OP_CLR  = 6'b010011;
    localparam logic [5:0] OP_RD   = 6'b010100;
    localparam logic [5:0] OP_RELU = 6'b011000;

    // Truncating BF16 a*b+c: zero exponent means zero, exponent wraps mod 256.
    function automatic logic [15:0] bf16_fma(input logic [15:0] a,
                                             input logic [15:0] b,
                                             input logic [15:0] c);
        logic [15:0] prod;
        logic        sp, sbig, ssml;
        logic [7:0]  ep, ebig, esml, ediff, eres;
        logic [15:0] mp, mc, mbig, msml, msh;
        logic [16:0] sum, norm;
        logic [4:0]  lead;
        prod = {8'h00, 1'b1, a[6:0]} * {8'h00, 1'b1, b[6:0]};
        if ((a[14:7] == 8'd0) || (b[14:7] == 8'd0)) begin
            sp = 1'b0;
            ep = 8'd0;
            mp = 16'd0;
        end else begin
            sp = a[15] ^ b[15];
            ep = a[14:7] + b[14:7] - 8'd127 + {7'd0, prod[15]};
            mp = prod[15] ? (prod & 16'hFF00) : ((prod << 1) & 16'hFF00);
        end
        mc = (c[14:7] == 8'd0) ? 16'd0 : {1'b1, c[6:0], 8'h00};
        // Larger magnitude stays put; the other one is shifted to align.
        if ({ep, mp} >= {c[14:7], mc}) begin
            sbig = sp;    ebig = ep;      mbig = mp;
            ssml = c[15]; esml = c[14:7]; msml = mc;
        end else begin
            sbig = c[15]; ebig = c[14:7]; mbig = mc;
            ssml = sp;    esml = ep;      msml = mp;
        end
        ediff = ebig - esml;
        msh   = (ediff > 8'd15) ? 16'd0 : (msml >> ediff[3:0]);
        if (sbig == ssml) sum = {1'b0, mbig} + {1'b0, msh};
        else              sum = {1'b0, mbig} - {1'b0, msh};
        lead = 5'd0;
        for (int i = 0; i < 17; i++) begin
            if (sum[i]) lead = 5'(i);
        end
        // Hidden one sits at bit 15 for an unshifted result.
        eres = ebig + {3'b000, lead} - 8'd15;
        norm = sum << (5'd16 - lead);
        if (sum == 17'd0) return 16'h0000;
        return {sbig, eres, 7'(norm >> 9)};
    endfunction

    logic         s1_valid_q, s2_valid_q;
    logic [5:0]   s1_op_q;
    logic [W-1:0] s1_a_q, s1_b_q, s1_c_q;
    logic [W-1:0] s2_res_q, acc_q;
    logic [W-1:0] res_d, acc_d;
    logic         acc_we;
    logic         s1_adv, s2_adv;

    assign s2_adv    = !s2_valid_q || out_ready;
    assign s1_adv    = s1_valid_q && s2_adv;
    assign in_ready  = !reset && (!s1_valid_q || s2_adv);
    assign out_valid = s2_valid_q;
    assign tu_result = s2_res_q;
    assign acc_data  = acc_q;

    // Lane compute from S1, plus the accumulator value to commit on advance.
    always_comb begin
        res_d  = '0;
        acc_d  = acc_q;
        acc_we = 1'b0;
        case (s1_op_q)
            OP_MUL: begin
                for (int i = 0; i < LANES; i++)
                    res_d[16*i +: 16] = bf16_fma(s1_a_q[16*i +: 16], s1_b_q[16*i +: 16], 16'h0000);
            end
            OP_FMA: begin
                for (int i = 0; i < LANES; i++)
                    res_d[16*i +: 16] = bf16_fma(s1_a_q[16*i +: 16], s1_b_q[16*i +: 16], s1_c_q[16*i +: 16]);
            end
            OP_MAC: begin
                if (ACC_EN) begin
                    for (int i = 0; i < LANES; i++)
                        res_d[16*i +: 16] = bf16_fma(s1_a_q[16*i +: 16], s1_b_q[16*i +: 16], acc_q[16*i +: 16]);
                    acc_d  = res_d;
                    acc_we = 1'b1;
                end
            end
            OP_CLR: begin
                if (ACC_EN) begin
                    acc_d  = '0;
                    acc_we = 1'b1;
                end
            end
            OP_RD: begin
                if (ACC_EN) res_d = acc_q;
            end
            OP_RELU: begin
                for (int i = 0; i < LANES; i++)
                    res_d[16*i +: 16] = s1_a_q[16*i+15] ? 16'h0000 : s1_a_q[16*i +: 16];
            end
            default: ;
        endcase
    end

    // S1 operand capture; contents are only meaningful while s1_valid_q is set.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_op_q <= tu_op;
            s1_a_q  <= rs1_data;
            s1_b_q  <= rs2_data;
            s1_c_q  <= rs3_data;
        end
    end

    // Stage valids, S2 result and accumulator; all advance together on one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            acc_q      <= '0;
        end else begin
            if (in_ready) s1_valid_q <= in_valid;
            if (s2_adv)   s2_valid_q <= s1_valid_q;
            if (s1_adv)   s2_res_q   <= res_d;
            if (s1_adv && acc_we) acc_q <= acc_d;
        end
    end

endmodule

// File: tb/tb_tensor_unit_pipe.sv
// Directed bench for tensor_unit_pipe: table of single-op vectors streamed
// back to back, plus hand-written MAC, back-pressure and reset sequences,
// and a short check of an 8-lane instance.
module tb_tensor_unit_pipe;

    localparam logic [5:0] OP_MUL  = 6'b010000;
    localparam logic [5:0] OP_FMA  = 6'b010001;
    localparam logic [5:0] OP_MAC  = 6'b010010;
    localparam logic [5:0] OP_CLR  = 6'b010011;
    localparam logic [5:0] OP_RD   = 6'b010100;
    localparam logic [5:0] OP_RELU = 6'b011000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid;
    logic [5:0]  tu_op = 6'd0;
    logic [63:0] rs1 = '0, rs2 = '0, rs3 = '0;
    logic [63:0] tu_result, acc_data;

    logic         in_valid8 = 1'b0, in_ready8, out_valid8;
    logic [5:0]   tu_op8 = 6'd0;
    logic [127:0] a8 = '0, b8 = '0, c8 = '0, res8, acc8;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    tensor_unit_pipe #(.LANES(4), .ACC_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .tu_op(tu_op), .rs1_data(rs1), .rs2_data(rs2), .rs3_data(rs3),
        .out_valid(out_valid), .out_ready(out_ready),
        .tu_result(tu_result), .acc_data(acc_data)
    );

    tensor_unit_pipe #(.LANES(8), .ACC_EN(1'b1)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .tu_op(tu_op8), .rs1_data(a8), .rs2_data(b8), .rs3_data(c8),
        .out_valid(out_valid8), .out_ready(1'b1),
        .tu_result(res8), .acc_data(acc8)
    );

    typedef struct packed {
        logic [5:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        logic [63:0] r;
    } vec_t;

    vec_t tbl [10];

    function automatic logic [63:0] rep4(input logic [15:0] x);
        return {4{x}};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] c);
        in_valid = 1'b1;
        tu_op = op;
        rs1 = a;
        rs2 = b;
        rs3 = c;
        cycle();
    endtask

    logic [63:0] exp_bp [4];
    logic [63:0] cap;
    logic        hs_in, hs_out;
    int          sent, got;

    initial begin
        tbl[0] = '{OP_MUL,  64'h0000_0000_0000_4000, 64'h0000_0000_0000_4040, 64'h0,
                            64'h0000_0000_0000_40C0};
        tbl[1] = '{OP_FMA,  64'h0000_0000_4000_0000, 64'h0000_0000_4040_0000, 64'h0000_0000_3F80_0000,
                            64'h0000_0000_40E0_0000};
        tbl[2] = '{OP_RELU, 64'hBF80_3F80_8000_4000, 64'h1234_5678_9ABC_DEF0, 64'h0,
                            64'h0000_3F80_0000_4000};
        tbl[3] = '{OP_FMA,  rep4(16'h3F80), rep4(16'h3F80), rep4(16'hBF80), rep4(16'h0000)};
        tbl[4] = '{OP_FMA,  rep4(16'h0040), rep4(16'h4000), rep4(16'h3F80), rep4(16'h3F80)};
        tbl[5] = '{OP_BAD,  rep4(16'h4000), rep4(16'h4040), rep4(16'h3F80), rep4(16'h0000)};
        tbl[6] = '{OP_MUL,  rep4(16'hC000), rep4(16'h4000), rep4(16'h3F80), rep4(16'hC080)};
        tbl[7] = '{OP_FMA,  rep4(16'h4040), rep4(16'h4000), rep4(16'hBF80), rep4(16'h40A0)};
        tbl[8] = '{OP_FMA,  rep4(16'h4000), rep4(16'h3F80), rep4(16'h3800), rep4(16'h4000)};
        tbl[9] = '{OP_FMA,  rep4(16'h3F80), rep4(16'h3F80), rep4(16'h4080), rep4(16'h40A0)};

        // Reset state
        #2 reset = 1'b1;
        #1;
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_in_ready", {127'd0, in_ready}, 128'd0);
        check("rst_result", {64'd0, tu_result}, 128'd0);
        check("rst_acc", {64'd0, acc_data}, 128'd0);
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        check("in_ready_after_rst", {127'd0, in_ready}, 128'd1);

        // MAC chain: CLR, 3 MACs of 1.0*2.0, then read-out
        issue(OP_CLR, '0, '0, '0);
        issue(OP_MAC, rep4(16'h3F80), rep4(16'h4000), '0);
        check("clr_result", {64'd0, tu_result}, 128'd0);
        check("clr_valid", {127'd0, out_valid}, 128'd1);
        issue(OP_MAC, rep4(16'h3F80), rep4(16'h4000), '0);
        check("mac1", {64'd0, tu_result}, {64'd0, rep4(16'h4000)});
        issue(OP_MAC, rep4(16'h3F80), rep4(16'h4000), '0);
        check("mac2", {64'd0, tu_result}, {64'd0, rep4(16'h4080)});
        issue(OP_RD, '0, '0, '0);
        check("mac3", {64'd0, tu_result}, {64'd0, rep4(16'h40C0)});
        check("mac_acc", {64'd0, acc_data}, {64'd0, rep4(16'h40C0)});
        in_valid = 1'b0;
        cycle();
        check("acc_rd", {64'd0, tu_result}, {64'd0, rep4(16'h40C0)});

        // Table streamed one per cycle; result of vector k-1 checked after edge k
        for (int k = 0; k <= 10; k++) begin
            if (k < 10) begin
                in_valid = 1'b1;
                tu_op = tbl[k].op;
                rs1 = tbl[k].a;
                rs2 = tbl[k].b;
                rs3 = tbl[k].c;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check($sformatf("stream_ready[%0d]", k), {127'd0, in_ready}, 128'd1);
            cycle();
            if (k >= 1) begin
                check($sformatf("tbl_valid[%0d]", k - 1), {127'd0, out_valid}, 128'd1);
                check($sformatf("tbl_result[%0d]", k - 1), {64'd0, tu_result}, {64'd0, tbl[k-1].r});
            end
        end
        cycle();
        check("acc_kept", {64'd0, acc_data}, {64'd0, rep4(16'h40C0)});
        check("drained", {127'd0, out_valid}, 128'd0);

        // Back-pressure: 4 MACs with out_ready low for the first 3 cycles
        issue(OP_CLR, '0, '0, '0);
        in_valid = 1'b0;
        cycle();
        cycle();
        check("bp_acc_clr", {64'd0, acc_data}, 128'd0);
        exp_bp[0] = rep4(16'h4000);
        exp_bp[1] = rep4(16'h4080);
        exp_bp[2] = rep4(16'h40C0);
        exp_bp[3] = rep4(16'h4100);
        sent = 0;
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            out_ready = (cyc >= 3);
            in_valid = (sent < 4);
            tu_op = OP_MAC;
            rs1 = rep4(16'h3F80);
            rs2 = rep4(16'h4000);
            #1;
            if (cyc == 2) begin
                check("bp_sent2", sent, 2);
                check("bp_in_ready_low", {127'd0, in_ready}, 128'd0);
                check("bp_hold_valid", {127'd0, out_valid}, 128'd1);
                check("bp_hold_result", {64'd0, tu_result}, {64'd0, rep4(16'h4000)});
                check("bp_stalled_acc", {64'd0, acc_data}, {64'd0, rep4(16'h4000)});
            end
            hs_in = in_valid && in_ready;
            hs_out = out_valid && out_ready;
            cap = tu_result;
            cycle();
            if (cyc == 2)
                check("bp_hold_next", {64'd0, tu_result}, {64'd0, rep4(16'h4000)});
            if (hs_in) sent++;
            if (hs_out) begin
                check($sformatf("bp_result[%0d]", got), {64'd0, cap}, {64'd0, exp_bp[got]});
                got++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_count", got, 4);
        check("bp_final_acc", {64'd0, acc_data}, {64'd0, rep4(16'h4100)});
        cycle();
        check("bp_no_dup", {127'd0, out_valid}, 128'd0);

        // Reset with two ops in flight and acc = 0x40C0
        issue(OP_CLR, '0, '0, '0);
        issue(OP_MAC, rep4(16'h3F80), rep4(16'h4000), '0);
        issue(OP_MAC, rep4(16'h3F80), rep4(16'h4000), '0);
        issue(OP_MAC, rep4(16'h3F80), rep4(16'h4000), '0);
        issue(OP_MUL, rep4(16'h4000), rep4(16'h4040), '0);
        issue(OP_MUL, rep4(16'h4000), rep4(16'h4040), '0);
        in_valid = 1'b0;
        check("pre_rst_acc", {64'd0, acc_data}, {64'd0, rep4(16'h40C0)});
        check("pre_rst_valid", {127'd0, out_valid}, 128'd1);
        #1 reset = 1'b1;
        #1;
        check("async_out_valid", {127'd0, out_valid}, 128'd0);
        check("async_acc", {64'd0, acc_data}, 128'd0);
        check("async_result", {64'd0, tu_result}, 128'd0);
        check("async_in_ready", {127'd0, in_ready}, 128'd0);
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        check("rel_in_ready", {127'd0, in_ready}, 128'd1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check($sformatf("no_stale[%0d]", i), {127'd0, out_valid}, 128'd0);
        end

        // 8-lane instance: lane 7 computes independently of lanes 0..6
        in_valid8 = 1'b1;
        tu_op8 = OP_FMA;
        a8 = {16'h4000, {7{16'h3F80}}};
        b8 = {16'h4040, {7{16'h3F80}}};
        c8 = {16'h3F80, {7{16'hBF80}}};
        cycle();
        a8 = {16'h3F80, {7{16'h4000}}};
        b8 = {16'h3F80, {7{16'h4040}}};
        c8 = {16'hBF80, {7{16'h3F80}}};
        cycle();
        in_valid8 = 1'b0;
        check("l8_valid0", {127'd0, out_valid8}, 128'd1);
        check("l8_result0", res8, {16'h40E0, {7{16'h0000}}});
        cycle();
        check("l8_result1", res8, {16'h0000, {7{16'h40E0}}});
        cycle();
        check("l8_drained", {127'd0, out_valid8}, 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
